// File: rtl/i2c_slave.sv
// I2C target with an 8-bit register-file port: oversampled SCL/SDA, START/STOP detection, 7-bit address match.
// Defining I2C_SLAVE_FILTER_EN adds a persistence glitch filter (FILTER_LEN samples) on both synchronized lines.
module i2c_slave #(
  parameter logic [6:0] OWN_ADDR = 7'h3C
`ifdef I2C_SLAVE_FILTER_EN
  ,
  parameter int FILTER_LEN = 3
`endif
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic [3:0] state
);
  // Bus handshake: the slave only ever pulls SDA low (sda_oe=1) and changes sda_oe on SCL falling edges.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_REG       = 4'd3,
    ST_REG_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_t;

  state_t     r_state, w_state_nxt;
  logic       r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
  logic       w_scl, w_sda, r_scl_d, r_sda_d;
  logic       w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] r_shift, w_shift_nxt, w_byte;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic       r_sda_oe, w_sda_oe_nxt;
  logic       r_wr_valid, w_wr_valid_nxt;
  logic [7:0] r_wr_addr, w_wr_addr_nxt, r_wr_data, w_wr_data_nxt;
  logic [7:0] r_rd_addr, w_rd_addr_nxt;
  logic       r_inc, w_inc_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_rw, w_rw_nxt;
  logic       r_mack, w_mack_nxt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= scl_in;
      r_scl_s2 <= r_scl_s1;
      r_sda_s1 <= sda_in;
      r_sda_s2 <= r_sda_s1;
      r_scl_d  <= w_scl;
      r_sda_d  <= w_sda;
    end
  end

`ifdef I2C_SLAVE_FILTER_EN
  localparam int FC_W = $clog2(FILTER_LEN + 1);
  logic            r_scl_f, r_sda_f;
  logic [FC_W-1:0] r_scl_fc, r_sda_fc;

  // Filtered value flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_scl_f  <= 1'b1;
      r_sda_f  <= 1'b1;
      r_scl_fc <= '0;
      r_sda_fc <= '0;
    end else begin
      if (r_scl_s2 == r_scl_f) r_scl_fc <= '0;
      else if (r_scl_fc == FC_W'(FILTER_LEN - 1)) begin
        r_scl_f  <= r_scl_s2;
        r_scl_fc <= '0;
      end else r_scl_fc <= r_scl_fc + FC_W'(1);
      if (r_sda_s2 == r_sda_f) r_sda_fc <= '0;
      else if (r_sda_fc == FC_W'(FILTER_LEN - 1)) begin
        r_sda_f  <= r_sda_s2;
        r_sda_fc <= '0;
      end else r_sda_fc <= r_sda_fc + FC_W'(1);
    end
  end
  assign w_scl = r_scl_f;
  assign w_sda = r_sda_f;
`else
  assign w_scl = r_scl_s2;
  assign w_sda = r_sda_s2;
`endif

  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_byte     = {r_shift[6:0], w_sda};

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_cnt_nxt      = r_cnt;
    w_sda_oe_nxt   = r_sda_oe;
    w_wr_valid_nxt = 1'b0;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_data_nxt  = r_wr_data;
    w_rd_addr_nxt  = r_inc ? r_rd_addr + 8'd1 : r_rd_addr;
    w_inc_nxt      = 1'b0;
    w_busy_nxt     = r_busy;
    w_rw_nxt       = r_rw;
    w_mack_nxt     = r_mack;
    if (w_stop) begin
      w_state_nxt  = ST_IDLE;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else if (w_start) begin
      w_state_nxt  = ST_ADDR;
      w_cnt_nxt    = 3'd7;
      w_sda_oe_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR: if (w_scl_rise) begin
          w_shift_nxt = w_byte;
          w_cnt_nxt   = r_cnt - 3'd1;
          if (r_cnt == 3'd0) begin
            if (w_byte[7:1] == OWN_ADDR) begin
              w_state_nxt = ST_ADDR_ACK;
              w_busy_nxt  = 1'b1;
              w_rw_nxt    = w_byte[0];
            end else w_state_nxt = ST_WAIT_STOP;
          end
        end
        ST_REG, ST_WDATA: if (w_scl_rise) begin
          w_shift_nxt = w_byte;
          w_cnt_nxt   = r_cnt - 3'd1;
          if (r_cnt == 3'd0) begin
            if (r_state == ST_REG) begin
              w_rd_addr_nxt = w_byte;
              w_state_nxt   = ST_REG_ACK;
            end else begin
              w_wr_valid_nxt = 1'b1;
              w_wr_addr_nxt  = r_rd_addr;
              w_wr_data_nxt  = w_byte;
              w_inc_nxt      = 1'b1;
              w_state_nxt    = ST_WDATA_ACK;
            end
          end
        end
        // First falling edge starts the ACK pulse, the second ends it.
        ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: if (w_scl_fall) begin
          if (!r_sda_oe) w_sda_oe_nxt = 1'b1;
          else begin
            w_sda_oe_nxt = 1'b0;
            w_cnt_nxt    = 3'd7;
            if (r_state == ST_ADDR_ACK && r_rw) begin
              w_state_nxt  = ST_RDATA;
              w_shift_nxt  = rd_data;
              w_sda_oe_nxt = ~rd_data[7];
            end else if (r_state == ST_ADDR_ACK) w_state_nxt = ST_REG;
            else w_state_nxt = ST_WDATA;
          end
        end
        ST_RDATA: if (w_scl_fall) begin
          if (r_cnt == 3'd0) begin
            w_sda_oe_nxt  = 1'b0;
            w_rd_addr_nxt = r_rd_addr + 8'd1;
            w_state_nxt   = ST_RDATA_ACK;
          end else begin
            w_shift_nxt  = {r_shift[6:0], 1'b0};
            w_sda_oe_nxt = ~r_shift[6];
            w_cnt_nxt    = r_cnt - 3'd1;
          end
        end
        ST_RDATA_ACK: begin
          if (w_scl_rise) w_mack_nxt = w_sda;
          if (w_scl_fall) begin
            if (!r_mack) begin
              w_state_nxt  = ST_RDATA;
              w_shift_nxt  = rd_data;
              w_sda_oe_nxt = ~rd_data[7];
              w_cnt_nxt    = 3'd7;
            end else w_state_nxt = ST_WAIT_STOP;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_shift    <= 8'd0;
      r_cnt      <= 3'd0;
      r_sda_oe   <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= 8'd0;
      r_wr_data  <= 8'd0;
      r_rd_addr  <= 8'd0;
      r_inc      <= 1'b0;
      r_busy     <= 1'b0;
      r_rw       <= 1'b0;
      r_mack     <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_wr_valid <= w_wr_valid_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_rd_addr  <= w_rd_addr_nxt;
      r_inc      <= w_inc_nxt;
      r_busy     <= w_busy_nxt;
      r_rw       <= w_rw_nxt;
      r_mack     <= w_mack_nxt;
    end
  end

  assign sda_oe   = r_sda_oe;
  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign rd_addr  = r_rd_addr;
  assign busy     = r_busy;
  assign state    = r_state;
endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master, bench-owned register file, and a transaction-level
// model (pointer + memory array) that predicts written pairs and read-back bytes.
module tb_i2c_slave;
  localparam int HALF = 10;
  localparam logic [6:0] OWN = 7'h3C;

  logic       clk, rst;
  logic       scl_m, sda_m, sda_bus;
  logic       sda_oe, wr_valid, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic [3:0] state;

  logic [7:0]  reg_mem [256];
  logic [7:0]  model_mem [256];
  logic [7:0]  model_ptr;
  logic [15:0] exp_q [$];
  logic [7:0]  wbuf [$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        oe_seen;

  assign sda_bus = sda_m & ~sda_oe;
  assign rd_data = reg_mem[rd_addr];

  i2c_slave dut (
    .CLK(clk), .RST(rst), .scl_in(scl_m), .sda_in(sda_bus), .sda_oe(sda_oe),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file owned by the bench
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) reg_mem[i] <= 8'd0;
    end else if (wr_valid) reg_mem[wr_addr] <= wr_data;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard for write strobes
  always @(negedge clk) begin
    if (!rst && wr_valid) begin
      n_checks++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL wr_unexpected: observed addr %h data %h expected no write", wr_addr, wr_data);
      end
      if (exp_q.size() > 0) check("wr_pair", {wr_addr, wr_data}, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (sda_oe) oe_seen = 1'b1;
    end
  endtask

  task automatic bus_bit(input logic b, output logic rx);
    tick(3); sda_m = b; tick(HALF - 3);
    scl_m = 1'b1; tick(HALF / 2); rx = sda_bus; tick(HALF - HALF / 2);
    scl_m = 1'b0;
  endtask

  task automatic bus_start();
    if (scl_m == 1'b0) begin
      tick(3); sda_m = 1'b1; tick(HALF - 3); scl_m = 1'b1;
    end
    tick(HALF / 2); sda_m = 1'b0; tick(HALF / 2); scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    tick(3); sda_m = 1'b0; tick(HALF - 3);
    scl_m = 1'b1; tick(HALF / 2); sda_m = 1'b1; tick(HALF);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic d;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], d);
    bus_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic d;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, d);
      b[i] = d;
    end
    bus_bit(mack, d);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model_mem[i] = 8'd0;
    model_ptr = 8'd0;
  endtask

  task automatic wr_txn(input logic [7:0] ptr);
    logic a;
    model_ptr = ptr;
    foreach (wbuf[i]) begin
      exp_q.push_back({model_ptr, wbuf[i]});
      model_mem[model_ptr] = wbuf[i];
      model_ptr = model_ptr + 8'd1;
    end
    bus_start();
    send_byte({OWN, 1'b0}, a); check("wr_addr_ack", 16'(a), 16'd0);
    send_byte(ptr, a);         check("wr_ptr_ack", 16'(a), 16'd0);
    foreach (wbuf[i]) begin
      send_byte(wbuf[i], a);   check("wr_data_ack", 16'(a), 16'd0);
    end
    bus_stop(); tick(5);
    check("wr_rd_addr", 16'(rd_addr), 16'(model_ptr));
    check("wr_busy_low", 16'(busy), 16'd0);
    check("wr_all_seen", 16'(exp_q.size()), 16'd0);
  endtask

  task automatic rd_txn(input logic [7:0] ptr, input int n);
    logic a;
    logic [7:0] b;
    bus_start();
    send_byte({OWN, 1'b0}, a); check("rd_addr_ack", 16'(a), 16'd0);
    send_byte(ptr, a);         check("rd_ptr_ack", 16'(a), 16'd0);
    model_ptr = ptr;
    bus_start();
    send_byte({OWN, 1'b1}, a); check("rd_addr_r_ack", 16'(a), 16'd0);
    check("rd_busy", 16'(busy), 16'd1);
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, b);
      check("rd_byte", 16'(b), 16'(model_mem[model_ptr]));
      model_ptr = model_ptr + 8'd1;
    end
    tick(6);
    check("rd_wait_stop", 16'(state), 16'd9);
    bus_stop(); tick(5);
    check("rd_idle", 16'(state), 16'd0);
    check("rd_rd_addr", 16'(rd_addr), 16'(model_ptr));
  endtask

  initial begin
    logic       a;
    logic [7:0] p;
    int         n;
    logic       saw;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; oe_seen = 1'b0; saw = 1'b0;
    model_reset();
    tick(5);
    check("rst_sda_oe", 16'(sda_oe), 16'd0);
    check("rst_wr_valid", 16'(wr_valid), 16'd0);
    check("rst_wr_pair", {wr_addr, wr_data}, 16'd0);
    check("rst_rd_addr", 16'(rd_addr), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_state", 16'(state), 16'd0);
    rst = 1'b0; tick(5);

    // directed write
    wbuf = {8'hAB, 8'hCD};
    wr_txn(8'h10);

    // directed read with repeated START
    wbuf = {8'h5A, 8'hA5};
    wr_txn(8'h20);
    rd_txn(8'h20, 2);

    // address miss
    oe_seen = 1'b0;
    bus_start();
    send_byte(8'h7A, a); check("miss_nack", 16'(a), 16'd1);
    tick(2);
    check("miss_state", 16'(state), 16'd9);
    check("miss_busy", 16'(busy), 16'd0);
    send_byte(8'h55, a);
    bus_stop(); tick(5);
    check("miss_no_drive", 16'(oe_seen), 16'd0);
    check("miss_idle", 16'(state), 16'd0);

    // pointer wrap
    wbuf = {8'h11, 8'h22};
    wr_txn(8'hFF);
    check("wrap_ptr", 16'(rd_addr), 16'h0001);

    // STOP after a partial data byte
    bus_start();
    send_byte({OWN, 1'b0}, a); send_byte(8'h40, a);
    model_ptr = 8'h40;
    for (int i = 0; i < 4; i++) bus_bit(1'($urandom_range(0, 1)), a);
    bus_stop(); tick(5);
    check("partial_idle", 16'(state), 16'd0);
    check("partial_ptr", 16'(rd_addr), 16'(model_ptr));
    check("partial_no_wr", 16'(exp_q.size()), 16'd0);

    // reset while ACK is driven
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(OWN_BIT(i), a);
    tick(6);
    check("abort_ack_driven", 16'(sda_oe), 16'd1);
    rst = 1'b1; tick(1);
    check("abort_sda_oe", 16'(sda_oe), 16'd0);
    check("abort_state", 16'(state), 16'd0);
    sda_m = 1'b1; tick(2); scl_m = 1'b1; tick(5);
    rst = 1'b0; model_reset(); tick(10);

    // randomized write/read-back
    for (int t = 0; t < 6; t++) begin
      p = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 4);
      wbuf.delete();
      for (int k = 0; k < n; k++) wbuf.push_back(8'($urandom_range(0, 255)));
      wr_txn(p);
      rd_txn(p, n + 1);
    end

`ifdef I2C_SLAVE_FILTER_EN
    saw = 1'b0;
    sda_m = 1'b0; tick(2); sda_m = 1'b1;
    for (int k = 0; k < 20; k++) begin tick(1); if (state == 4'd1) saw = 1'b1; end
    check("glitch_rejected", 16'(saw), 16'd0);
    sda_m = 1'b0; tick(3); sda_m = 1'b1;
    for (int k = 0; k < 20; k++) begin tick(1); if (state == 4'd1) saw = 1'b1; end
    check("pulse_start_seen", 16'(saw), 16'd1);
    check("pulse_then_stop", 16'(state), 16'd0);
`endif

    tick(20);
    check("final_queue_empty", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic OWN_BIT(input int i);
    logic [7:0] w;
    w = {OWN, 1'b0};
    return w[i];
  endfunction
endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (responder) for the bus driven by the team's I2C master.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, and acknowledges bytes.
- Exposes an 8-bit register-file interface: on writes, the first byte is the register pointer and later bytes are write strobes; on reads, it serves bytes from the pointer.
- Used as the bus-functional OLED/peripheral model in benches and as a configuration port in FPGA builds.

Parameters:
- OWN_ADDR, 7'h3C, 7-bit target address matched against the first byte after START.
- FILTER_LEN, 3, consecutive equal samples required by the glitch filter; only used with I2C_SLAVE_FILTER_EN.

Ports:
- CLK  input  1  system clock, at least 8x SCL frequency.
- RST  input  1  reset, synchronous, active-high.
- scl_in  input  1  raw SCL pad input.
- sda_in  input  1  raw SDA pad input.
- sda_oe  output  1  1 = pull SDA low; the pad wrapper drives 1'bz otherwise. Never drives high.
- wr_valid  output  1  one-CLK strobe; a data byte was written.
- wr_addr  output  8  register address for wr_valid.
- wr_data  output  8  data byte for wr_valid.
- rd_addr  output  8  current register pointer, continuously driven.
- rd_data  input  8  register contents at rd_addr; must be valid within 1 CLK of an rd_addr change.
- busy  output  1  high from an address-matched START until STOP.
- state  output  4  current FSM state, for debug and parallel monitors.

Behaviour:
- Reset (RST=1 at posedge CLK):
  - sda_oe=0, wr_valid=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, state=IDLE.
  - Shift register and bit counter cleared.
  - Reset mid-transfer releases SDA immediately, on the next CLK edge.
- Input path:
  - 2-FF synchronizer on scl_in and sda_in.
  - Edge detect on synced values against a 1-CLK delayed copy.
  - Event latency from pad to internal edge: 3 CLK.
- Bus events:
  - START: SDA falls while SCL=1.
  - STOP: SDA rises while SCL=1.
  - Both take priority over bit processing in the same CLK.
- Bit timing:
  - Receive bits sampled on SCL rising edge, MSB first.
  - Slave changes sda_oe only on SCL falling edge.
- States (4-bit encoding):
  - IDLE=0, ADDR=1, ADDR_ACK=2, REG=3, REG_ACK=4, WDATA=5, WDATA_ACK=6, RDATA=7, RDATA_ACK=8, WAIT_STOP=9.
- Transitions:
  - START in any state -> ADDR, bit counter=7. Repeated START is identical; the pointer is kept.
  - STOP in any state -> IDLE, sda_oe=0, busy=0.
  - ADDR, after 8 bits:
    - {OWN_ADDR,R/W} match -> ADDR_ACK, busy=1.
    - Mismatch -> WAIT_STOP, never drives SDA.
  - ADDR_ACK:
    - sda_oe=1 from the falling edge after bit 8 until the next falling edge.
    - Then -> REG if W=0.
    - Then -> RDATA if R=1; shift register loaded from rd_data and bit 7 driven (sda_oe = ~bit) on that same falling edge.
  - REG: 8 bits -> rd_addr <= byte; REG_ACK (ACK as above) -> WDATA.
  - WDATA: 8 bits -> WDATA_ACK.
    - wr_valid pulses 1 CLK at the 8th rising edge, with wr_addr=rd_addr and wr_data=byte.
    - rd_addr increments 1 CLK later.
    - ACK driven, then -> WDATA.
  - RDATA: shift out 8 bits, sda_oe = ~bit at each falling edge.
    - After the 8th falling edge, release SDA and rd_addr += 1 -> RDATA_ACK.
  - RDATA_ACK: sample SDA on the rising edge.
    - 0 (ACK): at the falling edge load rd_data (new pointer) -> RDATA.
    - 1 (NACK): -> WAIT_STOP.
  - WAIT_STOP: ignore bits; leave only on START or STOP.
- Pointer: 8-bit, wraps 8'hFF -> 8'h00 silently on both write and read.
- Reads issued before any pointer write serve from the retained rd_addr (0 after reset).
- Simultaneous wr_valid and STOP cannot occur; STOP after a partial byte discards the bits, with no wr_valid.

Optional Feature:
- Macro I2C_SLAVE_FILTER_EN.
- Defined: each synced line passes a majority/persistence filter; a filtered value changes only after FILTER_LEN consecutive equal samples. Adds FILTER_LEN CLK latency; pulses shorter than FILTER_LEN CLK are rejected.
- Undefined: no filter; any synced transition is an edge.

Test Plan:
- Write: START, 0x78, 0x10, 0xAB, 0xCD, STOP -> ACK on all 4 bytes; wr_valid twice, (0x10,0xAB) then (0x11,0xCD); rd_addr=0x12; busy low after STOP.
- Read: preload reg 0x20=0x5A and 0x21=0xA5; START 0x78 0x20, repeated START 0x79, master ACK then NACK -> bytes 0x5A, 0xA5 on SDA; state=WAIT_STOP, then IDLE on STOP.
- Address miss: START, 0x7A -> sda_oe stays 0 for the whole transfer; no wr_valid; busy=0.
- Wrap: pointer write 0xFF, data 0x11, 0x22 -> writes to 0xFF then 0x00; rd_addr=0x01.
- Abort: RST=1 while driving ACK -> sda_oe=0 next CLK, state=IDLE. Separately, STOP after 4 data bits -> no wr_valid.
- With I2C_SLAVE_FILTER_EN, FILTER_LEN=3: 2-CLK SDA low glitch while SCL high -> no START detected; 3-CLK pulse -> START detected.
